hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Parametrised load-use / jump-register hazard detector with multi-cycle stall sequencing.
//  Sits between the IF/ID and ID/EX pipeline registers. It holds PC and IF/ID and injects bubble
//  fields into ID/EX for a configurable number of cycles. Replaces the single-cycle, opcode-only stall logic.
// PARAMETERS
//  OPC_W      5        opcode width
//  RADDR_W    3        register address width
//  LOAD_LAT   1        stall cycles per load-use hazard (1..15)
//  JR_LAT     1        stall cycles when jr in IF/ID depends on ID/EX dest (0 = feature off, 0..15)
//  ADDR_MATCH 1        1: stall only on address match; 0: stall on every load in ID/EX
//  ZERO_SKIP  0        1: reg addr 0 never creates a hazard
//  OPC_LOAD   5'b11010 load opcode
//  OPC_JR     5'b11000 jump-register opcode
//  OPC_BUBBLE 5'h1f    opcode injected as bubble
// PORTS
//  CLK            in  1          clock, rising edge
//  RST            in  1          asynchronous, active-high reset
//  FLUSH          in  1          taken branch/jump: abort any stall sequence
//  IFID_OPCODE    in  OPC_W      opcode in IF/ID
//  IFID_R1_ADDR   in  RADDR_W    source 1 in IF/ID
//  IFID_R2_ADDR   in  RADDR_W    source 2 in IF/ID
//  IDEX_OPCODE    in  OPC_W      opcode in ID/EX
//  IDEX_RD_ADDR   in  RADDR_W    destination in ID/EX
//  STALL          out 1          hold PC and IF/ID; select bubble into ID/EX
//  STALL_OPCODE   out OPC_W      OPC_BUBBLE when STALL, else 0
//  STALL_RD_ADDR  out RADDR_W    all ones when STALL, else 0
//  STALL_R1_ADDR  out RADDR_W+1  all ones when STALL, else 0
//  STALL_R2_ADDR  out RADDR_W+1  all ones when STALL, else 0
//  STALL_CNT      out 4          remaining registered stall cycles (debug)
// BEHAVIOUR
//  - hit_ld  = IDEX_OPCODE==OPC_LOAD && (!ADDR_MATCH || R1==RD || R2==RD), qualified with RD!=0 if ZERO_SKIP.
//  - hit_jr  = JR_LAT>0 && IFID_OPCODE==OPC_JR && IFID_R1_ADDR==IDEX_RD_ADDR && IDEX_OPCODE!=OPC_BUBBLE.
//  - FSM states: IDLE, LD_WAIT, JR_WAIT; 4-bit down-counter CNT.
//  - IDLE: STALL = (hit_ld|hit_jr) & !FLUSH, combinational, in the same cycle as detection.
//    - hit_ld has priority over hit_jr.
//    - If hit_ld and LOAD_LAT>1: next state LD_WAIT, CNT<=LOAD_LAT-1.
//    - Else if hit_jr and JR_LAT>1: next state JR_WAIT, CNT<=JR_LAT-1.
//    - Otherwise remain in IDLE.
//  - LD_WAIT/JR_WAIT: STALL=1 unconditionally, inputs ignored; CNT decrements each cycle.
//    - When CNT==1, next state is IDLE.
//  - Total STALL cycles per event = LOAD_LAT or JR_LAT exactly.
//  - After a wait ends, IDLE re-evaluates the current inputs. The bubble in ID/EX must not re-trigger (OPC_BUBBLE != OPC_LOAD).
//  - FLUSH: highest priority in every state.
//    - STALL=0 in the same cycle; next state IDLE, CNT<=0.
//  - Bubble outputs follow STALL combinationally; zeros when STALL=0.
//  - RST asserted at any time (mid-sequence included): state IDLE, CNT=0, immediately.
//    - All outputs 0 while RST is high, regardless of inputs.
//  - Widths: CNT fixed 4 bits; LOAD_LAT/JR_LAT outside 0..15 is illegal (elaboration check). LOAD_LAT=0 is also illegal.
// STRUCTURE
//  - Shared pkg/header: opcode constants (OPC_LOAD, OPC_JR, OPC_BUBBLE), FSM state encodings, bubble field constants.
//  - One sub-module: hazard_cmp (pure combinational address/opcode compare producing hit_ld, hit_jr).
//  - FSM, counter and output muxing stay in the top.
// TESTING
//  1 LOAD_LAT=1: IDEX=load RD=3, IFID R1=3 -> STALL=1 that cycle only; STALL_OPCODE=5'h1f,
//    STALL_R1_ADDR=4'hf; next cycle (IDEX=bubble) STALL=0.
//  2 LOAD_LAT=3: load RD=2, IFID R2=2 -> STALL high exactly 3 cycles; STALL_CNT shows 2,1,0.
//  3 ADDR_MATCH=1: load RD=5, IFID R1=1,R2=4 -> STALL=0.
//    Repeat with ADDR_MATCH=0 -> STALL=1.
//  4 JR_LAT=2: IFID=jr R1=6, IDEX=add RD=6 -> 2 stall cycles.
//    Same cycle also a load hit -> load wins, LOAD_LAT cycles.
//  5 LOAD_LAT=4: FLUSH pulsed in 2nd stall cycle -> STALL=0 that cycle, STALL_CNT=0 next cycle.
//    RST pulsed mid-wait -> outputs 0 immediately, IDLE after release.
//  6 ZERO_SKIP=1: load RD=0, IFID R1=0 -> STALL=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared constants and types for the hazard stall controller
// Purpose: default widths, opcode encodings, bubble fill value, FSM state
//          encoding and the latency-to-counter helper.
// Ports:   none (package).
package hazard_stall_ctrl_pkg;

  localparam int DEF_OPC_W   = 5;
  localparam int DEF_RADDR_W = 3;
  localparam int CNT_W       = 4;
  localparam int MAX_LAT     = 15;

  localparam logic [DEF_OPC_W-1:0] DEF_OPC_LOAD   = 5'b11010;
  localparam logic [DEF_OPC_W-1:0] DEF_OPC_JR     = 5'b11000;
  localparam logic [DEF_OPC_W-1:0] DEF_OPC_BUBBLE = 5'h1f;

  // Bubble register-address fields are filled with this bit (all ones).
  localparam logic BUBBLE_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LD_WAIT = 2'd1,
    ST_JR_WAIT = 2'd2
  } stall_state_t;

  // The detection cycle itself is the first stall cycle, so the wait
  // state only has to cover the remaining lat-1 cycles.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side signal bundle for the hazard stall controller
// Purpose: groups the IF/ID and ID/EX fields, flush, and the stall/bubble outputs.
// Ports:   master drives flush + pipeline fields and receives stall outputs;
//          slave (the controller) is the reverse.
interface hazard_stall_ctrl_if #(
  parameter int OPC_W   = 5,
  parameter int RADDR_W = 3
);
  logic               flush;
  logic [OPC_W-1:0]   ifid_opcode;
  logic [RADDR_W-1:0] ifid_r1_addr;
  logic [RADDR_W-1:0] ifid_r2_addr;
  logic [OPC_W-1:0]   idex_opcode;
  logic [RADDR_W-1:0] idex_rd_addr;

  logic               stall;
  logic [OPC_W-1:0]   stall_opcode;
  logic [RADDR_W-1:0] stall_rd_addr;
  logic [RADDR_W:0]   stall_r1_addr;
  logic [RADDR_W:0]   stall_r2_addr;
  logic [3:0]         stall_cnt;

  modport master (
    output flush, ifid_opcode, ifid_r1_addr, ifid_r2_addr, idex_opcode, idex_rd_addr,
    input  stall, stall_opcode, stall_rd_addr, stall_r1_addr, stall_r2_addr, stall_cnt
  );

  modport slave (
    input  flush, ifid_opcode, ifid_r1_addr, ifid_r2_addr, idex_opcode, idex_rd_addr,
    output stall, stall_opcode, stall_rd_addr, stall_r1_addr, stall_r2_addr, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl_hazard_cmp.sv
// rtl/hazard_stall_ctrl_hazard_cmp.sv - combinational load-use / jump-register hazard compare
// Purpose: flags a load-use hazard (hit_ld) and a jr-on-ID/EX-dest hazard (hit_jr).
// Ports:   ifid_opcode/ifid_r1_addr/ifid_r2_addr, idex_opcode/idex_rd_addr in;
//          hit_ld, hit_jr out.
module hazard_cmp
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int               OPC_W      = DEF_OPC_W,
  parameter int               RADDR_W    = DEF_RADDR_W,
  parameter int               JR_LAT     = 1,
  parameter bit               ADDR_MATCH = 1'b1,
  parameter bit               ZERO_SKIP  = 1'b0,
  parameter logic [OPC_W-1:0] OPC_LOAD   = DEF_OPC_LOAD,
  parameter logic [OPC_W-1:0] OPC_JR     = DEF_OPC_JR,
  parameter logic [OPC_W-1:0] OPC_BUBBLE = DEF_OPC_BUBBLE
) (
  input  logic [OPC_W-1:0]   ifid_opcode,
  input  logic [RADDR_W-1:0] ifid_r1_addr,
  input  logic [RADDR_W-1:0] ifid_r2_addr,
  input  logic [OPC_W-1:0]   idex_opcode,
  input  logic [RADDR_W-1:0] idex_rd_addr,
  output logic               hit_ld,
  output logic               hit_jr
);
  logic rd_ok;
  logic r1_eq;
  logic r2_eq;

  // With ZERO_SKIP, r0 is hardwired and can never carry a dependency.
  assign rd_ok = !ZERO_SKIP || (idex_rd_addr != '0);
  assign r1_eq = (ifid_r1_addr == idex_rd_addr);
  assign r2_eq = (ifid_r2_addr == idex_rd_addr);

  assign hit_ld = (idex_opcode == OPC_LOAD) && (!ADDR_MATCH || r1_eq || r2_eq) && rd_ok;

  // A bubble in ID/EX writes nothing, so jr cannot depend on it.
  assign hit_jr = (JR_LAT > 0) && (ifid_opcode == OPC_JR) && r1_eq &&
                  (idex_opcode != OPC_BUBBLE) && rd_ok;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - multi-cycle load-use / jump-register stall controller
// Purpose: holds PC and IF/ID and selects bubble fields into ID/EX for
//          LOAD_LAT or JR_LAT cycles per detected hazard; flush aborts.
// Ports:   clk, rst (async, active high); bus (slave modport) carries flush,
//          IF/ID + ID/EX fields in and stall, bubble fields, stall_cnt out.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int               OPC_W      = DEF_OPC_W,
  parameter int               RADDR_W    = DEF_RADDR_W,
  parameter int               LOAD_LAT   = 1,
  parameter int               JR_LAT     = 1,
  parameter bit               ADDR_MATCH = 1'b1,
  parameter bit               ZERO_SKIP  = 1'b0,
  parameter logic [OPC_W-1:0] OPC_LOAD   = DEF_OPC_LOAD,
  parameter logic [OPC_W-1:0] OPC_JR     = DEF_OPC_JR,
  parameter logic [OPC_W-1:0] OPC_BUBBLE = DEF_OPC_BUBBLE
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus
);

  if (LOAD_LAT < 1 || LOAD_LAT > MAX_LAT) begin : g_bad_load_lat
    $error("hazard_stall_ctrl: LOAD_LAT must be 1..15");
  end
  if (JR_LAT < 0 || JR_LAT > MAX_LAT) begin : g_bad_jr_lat
    $error("hazard_stall_ctrl: JR_LAT must be 0..15");
  end

  localparam logic [CNT_W-1:0] LD_CNT_INIT = lat_to_cnt(LOAD_LAT);
  localparam logic [CNT_W-1:0] JR_CNT_INIT = lat_to_cnt(JR_LAT);

  stall_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic             hit_ld;
  logic             hit_jr;
  logic             stall;

  hazard_cmp #(
    .OPC_W      (OPC_W),
    .RADDR_W    (RADDR_W),
    .JR_LAT     (JR_LAT),
    .ADDR_MATCH (ADDR_MATCH),
    .ZERO_SKIP  (ZERO_SKIP),
    .OPC_LOAD   (OPC_LOAD),
    .OPC_JR     (OPC_JR),
    .OPC_BUBBLE (OPC_BUBBLE)
  ) u_cmp (
    .ifid_opcode  (bus.ifid_opcode),
    .ifid_r1_addr (bus.ifid_r1_addr),
    .ifid_r2_addr (bus.ifid_r2_addr),
    .idex_opcode  (bus.idex_opcode),
    .idex_rd_addr (bus.idex_rd_addr),
    .hit_ld       (hit_ld),
    .hit_jr       (hit_jr)
  );

  // Detection stalls in the same cycle; wait states stall regardless of
  // inputs. Reset and flush both force the outputs quiet at once.
  always_comb begin
    stall = 1'b0;
    if (!rst && !bus.flush) begin
      stall = (state == ST_IDLE) ? (hit_ld || hit_jr) : 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (bus.flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Load has priority; a single-cycle load stall stays in IDLE
          // rather than falling through to the jr sequence.
          if (hit_ld) begin
            if (LOAD_LAT > 1) begin
              state <= ST_LD_WAIT;
              cnt   <= LD_CNT_INIT;
            end
          end else if (hit_jr && JR_LAT > 1) begin
            state <= ST_JR_WAIT;
            cnt   <= JR_CNT_INIT;
          end
        end
        ST_LD_WAIT, ST_JR_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.stall         = stall;
  assign bus.stall_opcode  = stall ? OPC_BUBBLE : '0;
  assign bus.stall_rd_addr = stall ? {RADDR_W{BUBBLE_FILL}} : '0;
  assign bus.stall_r1_addr = stall ? {(RADDR_W+1){BUBBLE_FILL}} : '0;
  assign bus.stall_r2_addr = stall ? {(RADDR_W+1){BUBBLE_FILL}} : '0;
  assign bus.stall_cnt     = cnt;

endmodule
